// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the M stage, the DMA/loader master, dmem and the arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding system's view.
interface dmem_arbiter_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [2:0]  cpu_size;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;

   logic        dma_valid;
   logic        dma_ready;
   logic        dma_we;
   logic [2:0]  dma_size;
   logic [31:0] dma_addr;
   logic [31:0] dma_wdata;
   logic [31:0] dma_rdata;
   logic        dma_rvalid;

   logic        mem_we;
   logic [2:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] stall_cycles;

   modport slave (
      input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dma_valid, dma_we, dma_size, dma_addr, dma_wdata,
      output dma_ready, dma_rdata, dma_rvalid,
      output mem_we, mem_size, mem_addr, mem_wdata,
      input  mem_rdata,
      output stall_cycles
   );

   modport master (
      output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dma_valid, dma_we, dma_size, dma_addr, dma_wdata,
      input  dma_ready, dma_rdata, dma_rvalid,
      input  mem_we, mem_size, mem_addr, mem_wdata,
      output mem_rdata,
      input  stall_cycles
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares dmem between the CPU M stage and a DMA master. The CPU has priority.
// A starvation counter forces a DMA grant after STARVE_LIMIT refused cycles.
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic [31:0]   dma_rdata_q, dma_rdata_d;
   logic          dma_rvalid_q, dma_rvalid_d;
   logic [31:0]   stall_cycles_q, stall_cycles_d;

   logic dma_grant;
   logic cpu_grant;
   logic cpu_stall;

   always_comb begin
      dma_grant = bus.dma_valid & (~bus.cpu_req | (starve_cnt_q == LIMIT));
      cpu_grant = bus.cpu_req & ~dma_grant;
      cpu_stall = bus.cpu_req & ~cpu_grant;
   end

   always_comb begin
      bus.mem_size  = dma_grant ? bus.dma_size  : bus.cpu_size;
      bus.mem_addr  = dma_grant ? bus.dma_addr  : bus.cpu_addr;
      bus.mem_wdata = dma_grant ? bus.dma_wdata : bus.cpu_wdata;
      bus.mem_we    = (dma_grant & bus.dma_we) | (cpu_grant & bus.cpu_we);
   end

   always_comb begin
      starve_cnt_d   = starve_cnt_q;
      dma_rdata_d    = dma_rdata_q;
      dma_rvalid_d   = 1'b0;
      stall_cycles_d = stall_cycles_q;

      if (!bus.dma_valid || dma_grant)
         starve_cnt_d = '0;
      else if (starve_cnt_q != LIMIT)
         starve_cnt_d = starve_cnt_q + 1'b1;

      if (dma_grant && !bus.dma_we) begin
         dma_rdata_d  = bus.mem_rdata;
         dma_rvalid_d = 1'b1;
      end

      if (cpu_stall && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt_q   <= '0;
         dma_rdata_q    <= '0;
         dma_rvalid_q   <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         starve_cnt_q   <= starve_cnt_d;
         dma_rdata_q    <= dma_rdata_d;
         dma_rvalid_q   <= dma_rvalid_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   // While stalled the CPU sees the DMA access's read data; the pipeline ignores it.
   assign bus.cpu_rdata    = bus.mem_rdata;
   assign bus.cpu_stall    = cpu_stall;
   assign bus.dma_ready    = dma_grant;
   assign bus.dma_rdata    = dma_rdata_q;
   assign bus.dma_rvalid   = dma_rvalid_q;
   assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// against a refused-cycle-count reference model and a shadow copy of memory.
module tb_dmem_arbiter;
   localparam int unsigned LIMIT = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural dmem: combinational read, write at the rising edge.
   logic [31:0] dmem [256] = '{default: '0};
   assign bus.mem_rdata = dmem[bus.mem_addr[9:2]];
   always @(posedge clk) if (bus.mem_we) dmem[bus.mem_addr[9:2]] <= bus.mem_wdata;

   // Reference model state.
   logic [31:0] ref_mem [256] = '{default: '0};
   int unsigned m_wait;
   logic [31:0] m_rdata;
   logic        m_rvalid;
   logic [31:0] m_stall;
   logic        last_dma_grant;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wait = 0; m_rdata = '0; m_rvalid = 1'b0; m_stall = '0;
   endtask

   // One clock cycle with the inputs currently on the bus.
   task automatic step();
      logic e_dma, e_cpu, e_we, cr, cw, dv, dw;
      logic [31:0] e_addr, e_wdata, ca, da;
      #1;
      cr = bus.cpu_req; cw = bus.cpu_we; ca = bus.cpu_addr;
      dv = bus.dma_valid; dw = bus.dma_we; da = bus.dma_addr;
      e_dma   = dv && (!cr || m_wait >= LIMIT);
      e_cpu   = cr && !e_dma;
      e_addr  = e_dma ? da : ca;
      e_wdata = e_dma ? bus.dma_wdata : bus.cpu_wdata;
      e_we    = e_dma ? dw : (e_cpu ? cw : 1'b0);
      check("dma_ready", {31'b0, bus.dma_ready}, {31'b0, e_dma});
      check("cpu_stall", {31'b0, bus.cpu_stall}, {31'b0, cr && !e_cpu});
      check("mem_we", {31'b0, bus.mem_we}, {31'b0, e_we});
      if (e_dma || e_cpu) check("mem_addr", bus.mem_addr, e_addr);
      if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
      if (e_cpu && !cw) check("cpu_rdata", bus.cpu_rdata, ref_mem[ca[9:2]]);
      @(posedge clk);
      m_rvalid = 1'b0;
      if (e_dma && !dw) begin
         m_rdata  = ref_mem[da[9:2]];
         m_rvalid = 1'b1;
      end
      if (e_we) ref_mem[e_addr[9:2]] = e_wdata;
      if (!dv || e_dma) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
      if (cr && !e_cpu && m_stall != 32'hFFFF_FFFF) m_stall++;
      last_dma_grant = e_dma;
      #1;
      check("dma_rvalid", {31'b0, bus.dma_rvalid}, {31'b0, m_rvalid});
      check("dma_rdata", bus.dma_rdata, m_rdata);
      check("stall_cycles", bus.stall_cycles, m_stall);
   endtask

   task automatic idle_inputs();
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_size = 3'b010; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_valid = 0; bus.dma_we = 0; bus.dma_size = 3'b010; bus.dma_addr = '0; bus.dma_wdata = '0;
   endtask

   task automatic cpu_in(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
   endtask

   task automatic dma_in(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.dma_valid = v; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
   endtask

   // Asserts reset mid-cycle and checks the asynchronous clear right away.
   task automatic mid_reset();
      #2;
      idle_inputs();
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
      check("rst_rdata", bus.dma_rdata, 32'd0);
      check("rst_stall", bus.stall_cycles, 32'd0);
      check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      logic pend;
      idle_inputs();
      model_reset();
      last_dma_grant = 1'b0;
      @(posedge clk);
      mid_reset();

      // CPU only: store then load.
      cpu_in(1, 1, 32'h100, 32'hDEADBEEF); step();
      cpu_in(1, 0, 32'h100, 32'h0);
      #1;
      check("cpu_load_data", bus.cpu_rdata, 32'hDEADBEEF);
      step();
      check("cpu_only_stalls", bus.stall_cycles, 32'd0);
      cpu_in(0, 0, 0, 0);

      // DMA only: write then read, rvalid one cycle after the accept.
      dma_in(1, 1, 32'h200, 32'h12345678); step();
      dma_in(1, 0, 32'h200, 32'h0); step();
      check("dma_read_data", bus.dma_rdata, 32'h12345678);
      check("dma_read_valid", {31'b0, bus.dma_rvalid}, 32'd1);
      dma_in(0, 0, 0, 0);

      // Reset while dma_rvalid is high.
      mid_reset();

      // Contention: CPU x4 then forced DMA, repeating.
      cpu_in(1, 0, 32'h100, 0);
      dma_in(1, 0, 32'h200, 0);
      for (int i = 0; i < 10; i++) begin
         #1;
         check("pattern_ready", {31'b0, bus.dma_ready}, (i % 5 == 4) ? 32'd1 : 32'd0);
         step();
      end
      check("contention_stalls", bus.stall_cycles, 32'd2);

      // Starvation reset: 3 refusals, CPU drops, DMA granted at once.
      for (int i = 0; i < 3; i++) step();
      cpu_in(0, 0, 0, 0);
      #1;
      check("starve_grant", {31'b0, bus.dma_ready}, 32'd1);
      step();
      cpu_in(1, 0, 32'h100, 0);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("repattern_ready", {31'b0, bus.dma_ready}, (i == 4) ? 32'd1 : 32'd0);
         step();
      end

      // Reset with counter at 3 and a DMA read pending.
      for (int i = 0; i < 3; i++) step();
      mid_reset();
      cpu_in(1, 0, 32'h100, 0);
      dma_in(1, 0, 32'h200, 0);
      #1;
      check("post_rst_cpu_first", {31'b0, bus.cpu_stall}, 32'd0);
      step();
      for (int i = 0; i < 4; i++) step();
      idle_inputs();
      step();

      // Random traffic; a pending DMA request is held until accepted.
      pend = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pend && $urandom_range(0, 2) != 0) begin
            pend = 1'b1;
            dma_in(1, 1'($urandom_range(0, 1)), {22'b0, 8'($urandom_range(0, 15)), 2'b00}, $urandom);
         end
         if (!pend) dma_in(0, 0, 0, 0);
         cpu_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                {22'b0, 8'($urandom_range(0, 15)), 2'b00}, $urandom);
         step();
         if (last_dma_grant) pend = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (`dmem`) between the pipeline's Memory stage and a DMA/loader master. The CPU normally has priority; a starvation counter forces one DMA grant after a bounded wait. The arbiter sits between `riscv`/DMA and `dmem` in `top`. It drives `cpu_stall` back to the hazard unit so the M stage freezes while it is not granted.

## Interface
- `STARVE_LIMIT`, 4: consecutive refused DMA cycles before a forced DMA grant (≥1).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  M stage has a load or store this cycle.
- `cpu_we`  in  1  CPU store.
- `cpu_size`  in  3  CPU access size/sign code, passed through to `dmem`.
- `cpu_addr`  in  32  CPU address (`alu_outM`).
- `cpu_wdata`  in  32  CPU store data.
- `cpu_rdata`  out  32  CPU load data; equals `mem_rdata`.
- `cpu_stall`  out  1  `cpu_req` and CPU not granted this cycle.
- `dma_valid`  in  1  DMA request pending.
- `dma_ready`  out  1  DMA granted this cycle; the transfer completes at the next rising edge.
- `dma_we`, `dma_size`, `dma_addr`, `dma_wdata`  in  1/3/32/32  DMA request fields, held stable while `dma_valid` is high and `dma_ready` is low.
- `dma_rdata`  out  32  registered DMA load data.
- `dma_rvalid`  out  1  one-cycle pulse: `dma_rdata` was updated.
- `mem_we`, `mem_size`, `mem_addr`, `mem_wdata`  out  1/3/32/32  to `dmem`.
- `mem_rdata`  in  32  from `dmem` (combinational read).
- `stall_cycles`  out  32  saturating count of cycles with `cpu_stall` high.

## Operation
- Grant is combinational each cycle from the inputs and `starve_cnt`:
  - DMA wins if `dma_valid` and (`!cpu_req` or `starve_cnt == STARVE_LIMIT`).
  - Otherwise the CPU wins if `cpu_req`.
  - Otherwise nothing is granted.
- Memory mux select:
  - DMA when DMA is granted, else the CPU fields.
  - `mem_we = granted_we`; `mem_we` is 0 when nothing is granted, and no write occurs.
- `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`), updated at each edge:
  - Cleared if `!dma_valid` or `dma_ready`.
  - Else incremented, saturating at `STARVE_LIMIT`.
- Forced grant: a DMA wait never exceeds `STARVE_LIMIT` refused cycles. The following cycle is a DMA grant and `cpu_stall` is 1.
- After a forced grant the counter is cleared, so the CPU regains priority on the next cycle.
- DMA read: on an edge with `dma_ready & dma_valid & !dma_we`:
  - `dma_rdata <= mem_rdata`, `dma_rvalid <= 1`.
  - Otherwise `dma_rvalid <= 0` and `dma_rdata` holds its value.
- DMA write: `dmem` captures the write at the granted edge; `dma_rvalid` stays 0.
- CPU load: `cpu_rdata = mem_rdata` is valid only when CPU-granted. When stalled, `cpu_rdata` is don't-care; it is currently `mem_rdata` of the DMA access.
- `stall_cycles` increments on every edge with `cpu_stall = 1` and saturates at `32'hFFFF_FFFF`.

## Timing
- Reset values: `starve_cnt` 0, `dma_rdata` 0, `dma_rvalid` 0, `stall_cycles` 0.
- During reset the combinational outputs follow the grant equations with `starve_cnt` = 0, so `mem_we` = 0 unless a requester drives a write. Integration holds `cpu_req` and `dma_valid` low during reset.
- CPU access latency is 0 extra cycles when granted. Each refused cycle adds exactly one stall cycle.
- DMA: `dma_ready` can go high in the same cycle `dma_valid` rises. Read data arrives one cycle after the accept edge (`dma_rvalid`).
- Back-to-back DMA requests with `cpu_req = 0` are accepted every cycle. In that case `dma_rvalid` is high continuously for consecutive reads.
- Reset asserted mid-transfer:
  - A pending DMA request is dropped; DMA re-presents it after reset.
  - `dma_rvalid` clears immediately (asynchronous).
  - A write already captured at a prior edge is not undone.
- Simultaneous requests with the counter below the limit: CPU granted, DMA refused, counter increments.
- `dma_valid` dropping before it is granted is illegal; the arbiter only clears the counter.

## Test plan
- Reset: assert `reset` mid-cycle. Required: `dma_rvalid` = 0, `dma_rdata` = 0, `stall_cycles` = 0 immediately; `mem_we` = 0 with no requests.
- CPU only: store 0xDEADBEEF to 0x100 (word), then load 0x100. Required: `cpu_stall` = 0 in both cycles, `cpu_rdata` = 0xDEADBEEF, `stall_cycles` = 0.
- DMA only: write 0x12345678 to 0x200, then read 0x200. Required: `dma_ready` = 1 in both cycles; `dma_rvalid` pulses one cycle after the read accept with `dma_rdata` = 0x12345678.
- Contention, `STARVE_LIMIT` = 4: `cpu_req` and `dma_valid` held high continuously. Required grant pattern CPU,CPU,CPU,CPU,DMA repeating; `cpu_stall` high 1 cycle in 5; `stall_cycles` = 2 after 10 cycles.
- Starvation reset: DMA refused 3 cycles, then `cpu_req` drops. Required: DMA is granted immediately and the counter clears; the next contention again allows 4 CPU cycles before a forced DMA grant.
- Reset during a pending DMA read (counter = 3): required `dma_rvalid` = 0 and counter = 0 after reset; after reset is released, a CPU request is granted first.
